// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
//
// Purpose: common definitions used by the UART blocks.
//   uart_tx_state_e : transmit-buffer handshake FSM state (2 bits)
//   UART_DATA_W     : UART character width in bits
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } uart_tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered storage and occupancy count
//
// Purpose: circular buffer of DEPTH entries of WIDTH bits.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   push, wdata     : enqueue request and data (ignored while full)
//   pop             : dequeue request (ignored while empty)
//   rdata           : combinational view of the head entry
//   full, empty     : derived from count, not from pointer compare
//   count           : stored entries, 0..DEPTH
module sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Gating on the current full flag means a pop in the same cycle does not
  // make room for a write; the freed slot only exists after the edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - buffered transmit front end for the UART transmitter
//
// Purpose: queues system-side bytes and hands them to the transmitter one at
// a time with a start/done handshake.
// Optional feature macro: UART_TXBUF_OVF_EN (sticky overflow flag + clear).
// Ports:
//   clk, reset         : clock, asynchronous active-low reset
//   wr_en, wr_data     : byte write strobe and data
//   full, empty, count : FIFO status (count excludes the byte in flight)
//   tx_start, tx_data  : launch pulse and byte to the transmitter
//   tx_done            : frame-complete pulse from the transmitter
//   busy               : a byte is in flight
//   overflow, ovf_clr  : (UART_TXBUF_OVF_EN only) sticky drop flag and clear
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            count,
  output logic                   tx_start,
  output logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_done,
  output logic                   busy
`ifdef UART_TXBUF_OVF_EN
  ,
  input  logic                   ovf_clr,
  output logic                   overflow
`endif
);

  uart_tx_state_e         state_q, state_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic [UART_DATA_W-1:0] fifo_rdata;
  logic                   pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en),
    .pop   (pop),
    .wdata (wr_data),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    tx_start  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          tx_data_d = fifo_rdata;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start = 1'b1;
        busy     = 1'b1;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_data = tx_data_q;

`ifdef UART_TXBUF_OVF_EN
  logic overflow_q, overflow_d;

  // Clear wins over a same-cycle dropped write.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clr)             overflow_d = 1'b0;
    else if (wr_en && full)  overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`endif

endmodule
